// File: rtl/resync_2_pkg.sv
// -----------------------------------------------------------------------------
// resync_2_pkg
// Shared constants for the resync_2 multi-bit synchroniser.
//   RESYNC_2_STAGES_MIN / _MAX : legal range of the STAGES parameter
//   RESYNC_2_STAGES_DEF        : default chain depth
//   stages_legal()             : range check used at elaboration time
// -----------------------------------------------------------------------------
package resync_2_pkg;

    localparam int RESYNC_2_STAGES_MIN = 32'sd2;
    localparam int RESYNC_2_STAGES_MAX = 32'sd4;
    localparam int RESYNC_2_STAGES_DEF = 32'sd2;

    // True when a requested chain depth lies inside the supported range.
    function automatic bit stages_legal(input int stages);
        return (stages >= RESYNC_2_STAGES_MIN) && (stages <= RESYNC_2_STAGES_MAX);
    endfunction

endpackage : resync_2_pkg

// File: rtl/resync_2_bit.sv
// -----------------------------------------------------------------------------
// resync_2_bit
// Single-bit synchroniser: a plain shift chain of STAGES flops clocked by the
// destination clock, with asynchronous active-high reset to RST_VAL.
// Ports:
//   i_clk : destination-domain clock
//   i_rst : asynchronous active-high reset
//   i_d   : asynchronous input bit
//   o_q   : synchronised bit, taken straight from the last flop
// -----------------------------------------------------------------------------
module resync_2_bit
    import resync_2_pkg::*;
#(
    parameter int   STAGES  = RESYNC_2_STAGES_DEF,
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    // The chain must stay a set of discrete flops placed close together:
    // no SRL packing, no retiming, no optimisation across the stages.
    (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO", DONT_TOUCH = "TRUE", KEEP = "TRUE" *)
    logic [STAGES-1:0] chain_r;

    // Shift register: bit 0 samples the asynchronous input, top bit is the output.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            chain_r <= {STAGES{RST_VAL}};
        end else begin
            chain_r <= {chain_r[STAGES-2:0], i_d};
        end
    end

    assign o_q = chain_r[STAGES-1];

endmodule : resync_2_bit

// File: rtl/resync_2.sv
// -----------------------------------------------------------------------------
// resync_2
// WIDTH independent bit synchronisers into the i_clk domain. Bits carry no
// mutual coherency: when several bits change together they may land on
// different cycles.
// Parameters:
//   WIDTH   : number of independent bits
//   STAGES  : flops per chain (2..4); latency is STAGES edges
//   RST_VAL : reset value of every flop of every chain
// Ports:
//   i_clk  : destination-domain clock
//   i_rst  : asynchronous active-high reset
//   i_d    : asynchronous input bits
//   o_q    : synchronised bits, straight from the last flop of each chain
//   o_rise : one-cycle pulse on a 0->1 change of o_q   (RESYNC_2_EDGE_EN only)
//   o_fall : one-cycle pulse on a 1->0 change of o_q   (RESYNC_2_EDGE_EN only)
// Build option:
//   RESYNC_2_EDGE_EN : adds the edge-detect outputs and the previous-o_q register.
// -----------------------------------------------------------------------------
module resync_2
    import resync_2_pkg::*;
#(
    parameter int   WIDTH   = 1,
    parameter int   STAGES  = RESYNC_2_STAGES_DEF,
    parameter logic RST_VAL = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
`ifdef RESYNC_2_EDGE_EN
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall,
`endif
    output logic [WIDTH-1:0] o_q
);

    // Refuse to build a chain that is too short to be safe or needlessly deep.
    generate
        if (!stages_legal(STAGES)) begin : g_bad_stages
            $error("resync_2: STAGES out of range 2..4");
        end
    endgenerate

    // One independent chain per bit.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_bit
            resync_2_bit #(
                .STAGES  (STAGES),
                .RST_VAL (RST_VAL)
            ) u_chain (
                .i_clk (i_clk),
                .i_rst (i_rst),
                .i_d   (i_d[gi]),
                .o_q   (o_q[gi])
            );
        end
    endgenerate

`ifdef RESYNC_2_EDGE_EN
    logic [WIDTH-1:0] q_prev_r;

    // Copy of o_q one cycle late; reset to the same value as the chains so
    // that leaving reset never fakes an edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            q_prev_r <= {WIDTH{RST_VAL}};
        end else begin
            q_prev_r <= o_q;
        end
    end

    // Both terms are flop outputs, so each pulse lasts exactly the one cycle
    // between o_q changing and q_prev_r catching up. A bit cannot be both
    // 0->1 and 1->0, so rise and fall are mutually exclusive by construction.
    assign o_rise = o_q & ~q_prev_r;
    assign o_fall = ~o_q & q_prev_r;
`endif

endmodule : resync_2

// File: tb/tb_resync_2.sv
`timescale 1ns / 100ps
// -----------------------------------------------------------------------------
// tb_resync_2
// Self-checking bench for resync_2 (WIDTH=4, STAGES=2, RST_VAL=0, 83 ns clock).
// The reference model keeps a history of i_d values seen at each rising edge
// since reset; the expected o_q is the sample taken STAGES-1 edges ago.
// -----------------------------------------------------------------------------
module tb_resync_2;

    localparam int   W      = 4;
    localparam int   STG    = 2;
    localparam logic RSTV   = 1'b0;
    localparam logic [W-1:0] RST_WORD = {W{RSTV}};

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic [W-1:0] i_d   = 4'hF;
    logic [W-1:0] o_q;
`ifdef RESYNC_2_EDGE_EN
    logic [W-1:0] o_rise;
    logic [W-1:0] o_fall;
`endif

    int checks = 0;
    int errors = 0;

    resync_2 #(
        .WIDTH   (W),
        .STAGES  (STG),
        .RST_VAL (RSTV)
    ) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_d    (i_d),
`ifdef RESYNC_2_EDGE_EN
        .o_rise (o_rise),
        .o_fall (o_fall),
`endif
        .o_q    (o_q)
    );

    // 83 ns period; rising edges fall on x.5 ns so integer-time stimulus never races them.
    always #41.5 i_clk = ~i_clk;

    // Reference history: one entry per rising edge seen outside reset.
    logic [W-1:0] hist[$];

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hist.delete();
        end else begin
            hist.push_back(i_d);
            if (hist.size() > 16) void'(hist.pop_front());
        end
    end

    // Expected o_q now (back=0) or one edge ago (back=1).
    function automatic logic [W-1:0] exp_q(input int back);
        int idx;
        idx = hist.size() - STG - back;
        if (idx < 0) return RST_WORD;
        return hist[idx];
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic edge_sample();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk(tag, o_q, exp_q(0));
`ifdef RESYNC_2_EDGE_EN
        chk({tag, "_rise"}, o_rise, exp_q(0) & ~exp_q(1));
        chk({tag, "_fall"}, o_fall, ~exp_q(0) & exp_q(1));
        chk({tag, "_excl"}, o_rise & o_fall, 4'h0);
`endif
    endtask

    // Watchdog: the run is bounded in time no matter what the DUT does.
    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset test: reset held 170 ns with i_d=F, o_q must stay at reset value.
        for (int t = 0; t < 17; t++) begin
            #10;
            chk("rst_hold_q", o_q, RST_WORD);
`ifdef RESYNC_2_EDGE_EN
            chk("rst_hold_rise", o_rise, 4'h0);
            chk("rst_hold_fall", o_fall, 4'h0);
`endif
        end
        i_rst = 1'b0;                         // t = 170 ns
        edge_sample();                        // first edge after release
        chk("rst_first_edge", o_q, RST_WORD);
        chk_model("rst_first_model");

        // Latency test: 0 -> F just after edge k, visible after edge k+2.
        i_d = 4'h0;
        repeat (3) edge_sample();
        chk("lat_base", o_q, 4'h0);
        i_d = 4'hF;
        edge_sample();
        chk("lat_k1", o_q, 4'h0);
        edge_sample();
        chk("lat_k2", o_q, 4'hF);
        chk_model("lat_model");

        // Async reset test: mid-cycle reset clears o_q without a clock edge,
        // and the F still in the first stage is discarded.
        @(posedge i_clk);
        #20;
        i_rst = 1'b1;
        #1;
        chk("arst_immediate", o_q, 4'h0);
`ifdef RESYNC_2_EDGE_EN
        chk("arst_rise", o_rise, 4'h0);
        chk("arst_fall", o_fall, 4'h0);
`endif
        #5;
        i_rst = 1'b0;
        i_d   = 4'h0;
        edge_sample();
        chk("arst_flush1", o_q, 4'h0);
        chk_model("arst_model1");
        edge_sample();
        chk("arst_flush2", o_q, 4'h0);
        chk_model("arst_model2");

        // Glitch test: 5 ns pulse entirely between edges is never captured.
        @(posedge i_clk);
        #20;
        i_d = 4'hF;
        #5;
        i_d = 4'h0;
        for (int e = 0; e < 3; e++) begin
            edge_sample();
            chk("glitch_q", o_q, 4'h0);
`ifdef RESYNC_2_EDGE_EN
            chk("glitch_rise", o_rise, 4'h0);
`endif
        end

`ifdef RESYNC_2_EDGE_EN
        // Edge test: 0101 -> 1100 gives rise=1000, fall=0001 for one cycle.
        i_d = 4'b0101;
        repeat (3) edge_sample();
        chk("edge_base", o_q, 4'b0101);
        i_d = 4'b1100;
        edge_sample();
        chk("edge_k1_q", o_q, 4'b0101);
        chk("edge_k1_rise", o_rise, 4'b0000);
        edge_sample();
        chk("edge_k2_q", o_q, 4'b1100);
        chk("edge_k2_rise", o_rise, 4'b1000);
        chk("edge_k2_fall", o_fall, 4'b0001);
        edge_sample();
        chk("edge_k3_rise", o_rise, 4'b0000);
        chk("edge_k3_fall", o_fall, 4'b0000);
`endif

        // Random test: i_d changes every 1 ns for 1000 ns; o_q checked every ns
        // against the edge-sampled history, so any change off a rising edge shows.
        @(posedge i_clk);
        #0.5;
        for (int n = 0; n < 1000; n++) begin
            i_d = W'($urandom);
            #1;
            chk_model("rand");
        end

        // Random reset mid-stream, then more random traffic.
        #0.3;
        i_rst = 1'b1;
        #1;
        chk("rand_rst", o_q, RST_WORD);
        #0.7;
        i_rst = 1'b0;
        for (int n = 0; n < 300; n++) begin
            i_d = W'($urandom);
            #1;
            chk_model("rand_post_rst");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_resync_2

// File: doc/resync_2.md
RESYNC_2 -- requirements
Module: resync_2

Interface
REQ-001 Parameter WIDTH, default 1, number of independent bits resynchronised.
REQ-002 Parameter STAGES, default 2, number of flip-flops in each synchroniser chain; legal range 2..4.
REQ-003 Parameter RST_VAL, default 1'b0, value loaded into every flop of every chain on reset (applied to all bits).
REQ-004 i_clk  input  1  destination-domain clock; all flops update on its rising edge.
REQ-005 i_rst  input  1  reset, asynchronous and active-high.
REQ-006 i_d  input  WIDTH  asynchronous data; each bit is treated independently and sampled without timing assumptions.
REQ-007 o_q  output  WIDTH  resynchronised data, driven directly from the last flop of each chain.
REQ-008 o_rise  output  WIDTH  one-cycle pulse per bit on a 0->1 transition of o_q; present only with RESYNC_2_EDGE_EN.
REQ-009 o_fall  output  WIDTH  one-cycle pulse per bit on a 1->0 transition of o_q; present only with RESYNC_2_EDGE_EN.

Function
REQ-010 Each bit SHALL pass through a shift chain of STAGES flops, with no combinational logic between flops or on o_q.
REQ-011 A value stable on i_d[n] at rising edge k SHALL appear on o_q[n] after rising edge k+STAGES-1, giving 2 edges of latency for STAGES=2.
REQ-012 A pulse on i_d shorter than one i_clk period MAY be lost; the block SHALL NOT stretch or capture glitches.
REQ-013 A bit that is held constant for at least STAGES edges SHALL yield o_q equal to that value.
REQ-014 Bits SHALL be independent; no cross-bit coherency is guaranteed when several bits change together.
REQ-015 An edge pulse (REQ-008/009) SHALL be asserted for exactly one cycle, in the cycle after o_q changes, using a registered copy of o_q.
REQ-016 o_rise[n] and o_fall[n] SHALL never be asserted simultaneously.

Reset
REQ-017 Asserting i_rst SHALL immediately, without waiting for a clock edge, set all chain flops and the previous-o_q register to RST_VAL.
REQ-018 During reset, o_q SHALL equal RST_VAL and o_rise/o_fall SHALL be 0.
REQ-019 After reset deassertion, o_q SHALL follow i_d per REQ-011, and no edge pulse SHALL occur unless o_q differs from RST_VAL.
REQ-020 Reset asserted mid-propagation SHALL discard all in-flight values.

Configuration
REQ-021 With macro RESYNC_2_EDGE_EN defined, the block SHALL include the o_rise/o_fall ports and the previous-o_q register.
REQ-022 With RESYNC_2_EDGE_EN undefined, those ports and that register SHALL be absent, and o_q behaviour SHALL be identical to the defined case.

Structure
REQ-023 Package resync_2_pkg SHALL hold the constants RESYNC_2_STAGES_MIN=2, RESYNC_2_STAGES_MAX=4 and RESYNC_2_STAGES_DEF=2.
REQ-024 Sub-module resync_2_bit (a single-bit chain of STAGES flops with async reset) SHALL be instantiated WIDTH times through a generate loop.
REQ-025 An elaboration-time check SHALL reject STAGES outside the range MIN..MAX.
REQ-026 Synthesis attributes SHALL mark the chain flops as asynchronous registers, and they SHALL not be retimed.

Verification
REQ-027 Reset test: i_rst=1 for 170 ns with i_clk period 83 ns, RST_VAL=0 -> o_q=0 throughout reset and o_q=0 at the first edge after release.
REQ-028 Latency test: i_d changes 0->1 just after edge k (STAGES=2) -> o_q=0 after edge k+1 and o_q=1 after edge k+2.
REQ-029 Random test: i_d randomised every 1 ns for 1000 ns -> o_q changes only on rising edges and always equals a value of i_d sampled 2 edges earlier.
REQ-030 Async reset test: assert i_rst mid-cycle while o_q=1 -> o_q=0 before the next edge.
REQ-031 Edge test, with RESYNC_2_EDGE_EN and WIDTH=4: i_d=4'b0101 then 4'b1100 -> o_rise=4'b1000 and o_fall=4'b0001, each for exactly one cycle.
REQ-032 Glitch test: a 5 ns i_d pulse placed between edges -> o_q does not change and no o_rise pulse occurs.
